// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions for the AXI-Lite initiator and its peers:
//   AXI_PROT_WIDTH / AXI_RESP_WIDTH : fixed AXI4-Lite sideband widths
//   axi_resp_t                      : BRESP/RRESP encodings
//   mst_state_t                     : initiator transaction FSM states
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    localparam int AXI_PROT_WIDTH = 3;
    localparam int AXI_RESP_WIDTH = 2;

    typedef enum logic [AXI_RESP_WIDTH-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } mst_state_t;

endpackage

// File: rtl/axi_lite_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// axi_lite_master_ctrl_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   modport master : initiator side (drives addresses, data, valids, b/r ready)
//   modport slave  : target side (drives readies, responses, read data)
// Parameters: AXI_DATA_WIDTH (32 or 64), AXI_ADDR_WIDTH.
// -----------------------------------------------------------------------------
interface axi_lite_master_ctrl_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4
);
    import axi_lite_pkg::*;

    // write address channel
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [AXI_PROT_WIDTH-1:0]   awprot;
    logic                        awvalid;
    logic                        awready;
    // write data channel
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    // write response channel
    logic [AXI_RESP_WIDTH-1:0]   bresp;
    logic                        bvalid;
    logic                        bready;
    // read address channel
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [AXI_PROT_WIDTH-1:0]   arprot;
    logic                        arvalid;
    logic                        arready;
    // read data channel
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [AXI_RESP_WIDTH-1:0]   rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_master_ctrl.sv
// -----------------------------------------------------------------------------
// axi_lite_master_ctrl
// AXI4-Lite initiator: converts single-beat commands on a valid/ready command
// port into one AXI4-Lite read or write, then returns the data/response on a
// valid/ready response port. One transaction outstanding at a time.
//
// Ports:
//   axi_clk, axi_s_rst_n        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready high only in IDLE)
//   cmd_we/addr/wdata/wstrb     command payload (wdata/wstrb unused for reads)
//   rsp_valid/rsp_ready         response handshake
//   rsp_we/rsp_rdata/rsp_resp   echo of direction, read data (0 on writes), resp
//   err_cnt                     saturating count of non-OKAY responses
//   m_axi                       AXI4-Lite master bus
// -----------------------------------------------------------------------------
module axi_lite_master_ctrl
    import axi_lite_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                        axi_clk,
    input  logic                        axi_s_rst_n,

    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_we,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [AXI_RESP_WIDTH-1:0]   rsp_resp,

    output logic [ERR_CNT_WIDTH-1:0]    err_cnt,

    axi_lite_master_ctrl_if.master      m_axi
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    mst_state_t                  state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]       wstrb_q;
    logic                        we_q;
    logic                        aw_done_q;
    logic                        w_done_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [AXI_RESP_WIDTH-1:0]   resp_q;
    logic [ERR_CNT_WIDTH-1:0]    err_cnt_q;

    logic aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_vld;
    logic cmd_hs, aw_hs, w_hs, b_hs, r_hs;
    logic [AXI_RESP_WIDTH-1:0] cap_resp;

    assign cmd_hs   = cmd_valid && cmd_ready;
    assign aw_hs    = aw_valid && m_axi.awready;
    assign w_hs     = w_valid && m_axi.wready;
    assign b_hs     = b_ready && m_axi.bvalid;
    assign r_hs     = r_ready && m_axi.rvalid;
    assign cap_resp = b_hs ? m_axi.bresp : m_axi.rresp;

    // state register
    always_ff @(posedge axi_clk or negedge axi_s_rst_n) begin
        if (!axi_s_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake outputs; every valid/ready is a pure function
    // of registered state, so nothing here depends combinationally on inputs
    // except the state transition itself
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        rsp_vld   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = cmd_we ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both have gone
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if ((aw_done_q || m_axi.awready) && (w_done_q || m_axi.wready))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (m_axi.bvalid) state_d = RSP;
            end
            RD_REQ: begin
                ar_valid = 1'b1;
                if (m_axi.arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                r_ready = 1'b1;
                if (m_axi.rvalid) state_d = RSP;
            end
            RSP: begin
                rsp_vld = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // command latch, per-channel done flags, response capture, error count
    always_ff @(posedge axi_clk or negedge axi_s_rst_n) begin
        if (!axi_s_rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            if (cmd_hs) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                we_q      <= cmd_we;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (b_hs) begin
                resp_q  <= m_axi.bresp;
                rdata_q <= '0;
            end else if (r_hs) begin
                resp_q  <= m_axi.rresp;
                rdata_q <= m_axi.rdata;
            end
            if ((b_hs || r_hs) && (cap_resp != OKAY))
                err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = '0;
    assign m_axi.awvalid = aw_valid;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = w_valid;
    assign m_axi.bready  = b_ready;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = '0;
    assign m_axi.arvalid = ar_valid;
    assign m_axi.rready  = r_ready;

    assign rsp_valid = rsp_vld;
    assign rsp_we    = we_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_ctrl
// Bench for axi_lite_master_ctrl: a configurable-latency AXI-Lite memory slave,
// a transaction-level reference (expected-response queue, reference memory,
// saturating error count, busy flag) checked every cycle, and directed
// sequences with hand-computed expectations.
// Drivers change inputs on the falling edge; the checker samples 1 ns later.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_ctrl;

    logic        axi_clk = 1'b0;
    logic        axi_s_rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_cnt;

    always #5 axi_clk = ~axi_clk;

    axi_lite_master_ctrl_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(4)) m_axi_if ();

    axi_lite_master_ctrl #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(4), .ERR_CNT_WIDTH(8)) dut (
        .axi_clk(axi_clk), .axi_s_rst_n(axi_s_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_cnt(err_cnt),
        .m_axi(m_axi_if)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] s_mem [4];
    logic [31:0] ref_mem [4];

    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, ar_got, b_fire, r_fire;
    logic [3:0] s_awaddr, s_araddr, s_wstrb;
    logic [31:0] s_wdata;

    initial begin
        s_mem[0] = 32'hCAFE0000; s_mem[1] = 32'h00C0FFEE;
        s_mem[2] = 32'h12345678; s_mem[3] = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) ref_mem[i] = s_mem[i];
    end

    initial begin
        m_axi_if.awready = 0; m_axi_if.wready = 0; m_axi_if.bvalid = 0; m_axi_if.bresp = 0;
        m_axi_if.arready = 0; m_axi_if.rvalid = 0; m_axi_if.rdata = 0; m_axi_if.rresp = 0;
        forever begin
            @(negedge axi_clk);
            if (!axi_s_rst_n) begin
                m_axi_if.awready = 0; m_axi_if.wready = 0; m_axi_if.bvalid = 0;
                m_axi_if.arready = 0; m_axi_if.rvalid = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
                continue;
            end
            // responses first, so they only follow already-completed beats
            if (b_fire) begin
                m_axi_if.bvalid = 0; b_fire = 0;
            end else if (!m_axi_if.bvalid && aw_got && w_got) begin
                if (b_cnt >= b_delay) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) s_mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    m_axi_if.bvalid = 1; m_axi_if.bresp = bresp_cfg;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (m_axi_if.bvalid && m_axi_if.bready) b_fire = 1;

            if (r_fire) begin
                m_axi_if.rvalid = 0; r_fire = 0;
            end else if (!m_axi_if.rvalid && ar_got) begin
                if (r_cnt >= r_delay) begin
                    m_axi_if.rvalid = 1; m_axi_if.rdata = s_mem[s_araddr[3:2]];
                    m_axi_if.rresp = rresp_cfg; ar_got = 0; r_cnt = 0;
                end else r_cnt++;
            end
            if (m_axi_if.rvalid && m_axi_if.rready) r_fire = 1;

            m_axi_if.awready = m_axi_if.awvalid && !aw_got && (aw_cnt >= aw_delay);
            if (m_axi_if.awready) begin
                aw_got = 1; s_awaddr = m_axi_if.awaddr; aw_cnt = 0;
            end else if (m_axi_if.awvalid) aw_cnt++;

            m_axi_if.wready = m_axi_if.wvalid && !w_got && (w_cnt >= w_delay);
            if (m_axi_if.wready) begin
                w_got = 1; s_wdata = m_axi_if.wdata; s_wstrb = m_axi_if.wstrb; w_cnt = 0;
            end else if (m_axi_if.wvalid) w_cnt++;

            m_axi_if.arready = m_axi_if.arvalid && !ar_got && (ar_cnt >= ar_delay);
            if (m_axi_if.arready) begin
                ar_got = 1; s_araddr = m_axi_if.araddr; ar_cnt = 0;
            end else if (m_axi_if.arvalid) ar_cnt++;
        end
    end

    // ---------------- reference model and per-cycle checker ----------------
    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [7:0]  err;
    } exp_t;

    exp_t exp_q[$];
    logic busy = 0;
    int   model_err = 0;
    int   aw_seen = 0, w_seen = 0;
    logic p_ok = 0;
    logic p_aw, p_awr, p_w, p_wr, p_ar, p_arr, p_rv, p_rr, p_rwe;
    logic [3:0]  p_awaddr, p_araddr, p_wstrb;
    logic [31:0] p_wdata, p_rdata;
    logic [1:0]  p_resp;

    initial forever begin
        exp_t e;
        @(negedge axi_clk); #1;
        if (!axi_s_rst_n) begin
            chk("rst_valids", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid,
                               m_axi_if.bready, m_axi_if.rready, rsp_valid}, 0);
            chk("rst_rsp", {rsp_we, rsp_resp, rsp_rdata}, 0);
            chk("rst_err_cnt", err_cnt, 0);
            chk("rst_regs", {m_axi_if.awaddr, m_axi_if.wdata, m_axi_if.wstrb}, 0);
            busy = 0; exp_q.delete(); model_err = 0; p_ok = 0; aw_seen = 0; w_seen = 0;
            continue;
        end
        chk("cmd_ready", cmd_ready, !busy);
        chk("prot", {m_axi_if.awprot, m_axi_if.arprot}, 0);
        if (!busy)
            chk("idle_quiet", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid,
                               m_axi_if.bready, m_axi_if.rready, rsp_valid}, 0);
        if (rsp_valid)
            chk("rsp_quiet", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid,
                              m_axi_if.bready, m_axi_if.rready}, 0);
        if (p_ok) begin
            if (p_aw && !p_awr) chk("aw_hold", {m_axi_if.awvalid, m_axi_if.awaddr}, {1'b1, p_awaddr});
            if (p_w && !p_wr) chk("w_hold", {m_axi_if.wvalid, m_axi_if.wdata, m_axi_if.wstrb},
                                  {1'b1, p_wdata, p_wstrb});
            if (p_ar && !p_arr) chk("ar_hold", {m_axi_if.arvalid, m_axi_if.araddr}, {1'b1, p_araddr});
            if (p_rv && !p_rr) chk("rsp_hold", {rsp_valid, rsp_we, rsp_resp, rsp_rdata},
                                   {1'b1, p_rwe, p_resp, p_rdata});
        end
        if (m_axi_if.bready) chk("b_after_aw_w", {aw_seen == 1, w_seen == 1}, 2'b11);
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (m_axi_if.awvalid && m_axi_if.awready) begin
                aw_seen++; chk("awaddr", m_axi_if.awaddr, e.addr);
            end
            if (m_axi_if.wvalid && m_axi_if.wready) begin
                w_seen++; chk("wdata", {m_axi_if.wdata, m_axi_if.wstrb}, {e.wdata, e.wstrb});
            end
            if (m_axi_if.arvalid && m_axi_if.arready) chk("araddr", m_axi_if.araddr, e.addr);
            if (m_axi_if.bvalid && m_axi_if.bready) begin
                chk("beats_per_write", {aw_seen[7:0], w_seen[7:0]}, 16'h0101);
                aw_seen = 0; w_seen = 0;
            end
            if (rsp_valid) begin
                chk("rsp_we", rsp_we, e.we);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp", rsp_resp, e.resp);
                chk("err_cnt", err_cnt, e.err);
                if (rsp_ready) begin
                    void'(exp_q.pop_front()); busy = 0;
                end
            end
        end else if (rsp_valid) begin
            chk("rsp_unexpected", rsp_valid, 0);
        end
        if (cmd_valid && cmd_ready) begin
            e.we = cmd_we; e.addr = cmd_addr; e.wdata = cmd_wdata; e.wstrb = cmd_wstrb;
            if (cmd_we) begin
                for (int b = 0; b < 4; b++)
                    if (cmd_wstrb[b]) ref_mem[cmd_addr[3:2]][8*b +: 8] = cmd_wdata[8*b +: 8];
                e.rdata = 0; e.resp = bresp_cfg;
            end else begin
                e.rdata = ref_mem[cmd_addr[3:2]]; e.resp = rresp_cfg;
            end
            if (e.resp != 2'b00 && model_err < 255) model_err++;
            e.err = 8'(model_err);
            exp_q.push_back(e);
            busy = 1;
        end
        p_aw = m_axi_if.awvalid; p_awr = m_axi_if.awready; p_awaddr = m_axi_if.awaddr;
        p_w = m_axi_if.wvalid; p_wr = m_axi_if.wready; p_wdata = m_axi_if.wdata; p_wstrb = m_axi_if.wstrb;
        p_ar = m_axi_if.arvalid; p_arr = m_axi_if.arready; p_araddr = m_axi_if.araddr;
        p_rv = rsp_valid; p_rr = rsp_ready; p_rwe = rsp_we; p_resp = rsp_resp; p_rdata = rsp_rdata;
        p_ok = 1;
    end

    // ---------------- directed stimulus ----------------
    int t_aw_first, t_w_first, t_b_first, aw_cyc, w_cyc, ar_cyc;
    logic aw_low_w_high;

    task automatic send_cmd(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output int waited);
        cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge axi_clk); waited++;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(negedge axi_clk);
        cmd_valid = 0;
        t_aw_first = -1; t_w_first = -1; t_b_first = -1;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0; aw_low_w_high = 0;
    endtask

    task automatic wait_rsp(output logic [31:0] rdata, output logic [1:0] resp,
                            output logic rwe, output int lat);
        lat = 1;
        forever begin
            if (m_axi_if.awvalid) begin if (t_aw_first < 0) t_aw_first = lat; aw_cyc++; end
            if (m_axi_if.wvalid) begin if (t_w_first < 0) t_w_first = lat; w_cyc++; end
            if (m_axi_if.arvalid) ar_cyc++;
            if (m_axi_if.bready && t_b_first < 0) t_b_first = lat;
            if (!m_axi_if.awvalid && m_axi_if.wvalid) aw_low_w_high = 1;
            if (rsp_valid || lat >= 60) break;
            @(negedge axi_clk); lat++;
        end
        chk("rsp_arrive", rsp_valid, 1);
        rdata = rsp_rdata; resp = rsp_resp; rwe = rsp_we;
    endtask

    task automatic ack_rsp(input int hold);
        repeat (hold) @(negedge axi_clk);
        rsp_ready = 1;
        @(negedge axi_clk);
        rsp_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        rw;
        int          lat, waited, n;
        cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(negedge axi_clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_outputs", {rsp_valid, rsp_we, rsp_resp, err_cnt, m_axi_if.awvalid,
                              m_axi_if.wvalid, m_axi_if.arvalid}, 0);
        axi_s_rst_n = 1;
        @(negedge axi_clk);

        // zero-wait write
        send_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, waited);
        wait_rsp(rd, rs, rw, lat);
        chk("t1_aw_cycle", t_aw_first, 1);
        chk("t1_w_cycle", t_w_first, 1);
        chk("t1_b_cycle", t_b_first, 2);
        chk("t1_latency", lat, 3);
        chk("t1_rsp", {rw, rs, rd}, {1'b1, 2'b00, 32'h0});
        ack_rsp(0);

        // slow ROM read
        ar_delay = 1; r_delay = 3;
        send_cmd(1'b0, 4'h8, 32'h0, 4'h0, waited);
        wait_rsp(rd, rs, rw, lat);
        chk("t2_ar_cycles", ar_cyc, 2);
        chk("t2_latency", lat, 7);
        chk("t2_rsp", {rw, rs, rd}, {1'b0, 2'b00, 32'h12345678});
        ack_rsp(2);
        ar_delay = 0; r_delay = 0;

        // AW accepted three cycles before W
        w_delay = 3;
        send_cmd(1'b1, 4'h0, 32'h11223344, 4'hF, waited);
        wait_rsp(rd, rs, rw, lat);
        chk("t3_aw_cycles", aw_cyc, 1);
        chk("t3_w_cycles", w_cyc, 4);
        chk("t3_aw_before_w", aw_low_w_high, 1);
        chk("t3_b_cycle", t_b_first, 5);
        chk("t3_latency", lat, 6);
        ack_rsp(0);
        w_delay = 0;

        // partial-strobe write; response back-pressured with the next command waiting
        send_cmd(1'b1, 4'hC, 32'hA5A50F0F, 4'h5, waited);
        wait_rsp(rd, rs, rw, lat);
        cmd_valid = 1; cmd_we = 0; cmd_addr = 4'hC; cmd_wdata = 0; cmd_wstrb = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_cmd_blocked", {cmd_ready, rsp_valid}, 2'b01);
            @(negedge axi_clk);
        end
        rsp_ready = 1;
        @(negedge axi_clk);
        rsp_ready = 0;
        chk("t5_cmd_ready_after_rsp", cmd_ready, 1);
        send_cmd(1'b0, 4'hC, 32'h0, 4'h0, waited);
        chk("t5_accept_immediate", waited, 0);
        wait_rsp(rd, rs, rw, lat);
        chk("t5_merged_rdata", rd, 32'h0BA5F00F);
        ack_rsp(0);
        send_cmd(1'b0, 4'h0, 32'h0, 4'h0, waited);
        wait_rsp(rd, rs, rw, lat);
        chk("t5_readback", rd, 32'h11223344);
        ack_rsp(0);

        // 300 SLVERR reads: counter saturates
        rresp_cfg = 2'b10;
        for (int i = 0; i < 300; i++) begin
            send_cmd(1'b0, 4'((i % 4) * 4), 32'h0, 4'h0, waited);
            wait_rsp(rd, rs, rw, lat);
            chk("t4_slverr", rs, 2'b10);
            if (i == 99) chk("t4_err_100", err_cnt, 8'd100);
            ack_rsp(0);
        end
        chk("t4_err_sat", err_cnt, 8'd255);
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b11;
        send_cmd(1'b1, 4'h4, 32'h55AA55AA, 4'hF, waited);
        wait_rsp(rd, rs, rw, lat);
        chk("t4_decerr", {rs, err_cnt}, {2'b11, 8'd255});
        ack_rsp(0);
        bresp_cfg = 2'b00;

        // reset while waiting for R
        r_delay = 6;
        send_cmd(1'b0, 4'h4, 32'h0, 4'h0, waited);
        n = 0;
        while (!m_axi_if.rready && n < 20) begin
            @(negedge axi_clk); n++;
        end
        chk("t6_in_rd_resp", m_axi_if.rready, 1);
        axi_s_rst_n = 0;
        #1;
        chk("t6_async_valids", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid,
                                m_axi_if.bready, m_axi_if.rready, rsp_valid}, 0);
        chk("t6_async_rsp", {rsp_we, rsp_resp, rsp_rdata, err_cnt}, 0);
        chk("t6_async_addr", {m_axi_if.araddr, m_axi_if.awaddr}, 0);
        repeat (2) @(negedge axi_clk);
        axi_s_rst_n = 1;
        r_delay = 0;
        @(negedge axi_clk);
        chk("t6_cmd_ready", cmd_ready, 1);
        send_cmd(1'b0, 4'h8, 32'h0, 4'h0, waited);
        wait_rsp(rd, rs, rw, lat);
        chk("t6_read_after_reset", {rs, rd}, {2'b00, 32'h12345678});
        chk("t6_latency", lat, 3);
        ack_rsp(0);

        repeat (3) @(negedge axi_clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
